// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the shared-adder controller and its arbiter.
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Default-width result type; controllers re-declare it at their own DATA_WIDTH.
    localparam int DEF_DATA_WIDTH = 8;
    typedef logic unsigned [DEF_DATA_WIDTH:0] sum_t;

    function automatic int req_id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = req_id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           any_req
);

    localparam int IW1 = IDW + 1;

    always_comb begin
        logic [IW1-1:0] idx;
        grant    = '0;
        grant_id = '0;
        any_req  = 1'b0;
        idx      = '0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                // ptr < N, so one conditional subtract is enough to wrap
                idx = {1'b0, ptr} + IW1'(i);
                if (idx >= IW1'(N))
                    idx = idx - IW1'(N);
                if (!any_req && req[idx[IDW-1:0]]) begin
                    any_req  = 1'b1;
                    grant_id = idx[IDW-1:0];
                end
            end
            if (any_req)
                grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// One registered adder shared by NUM_REQ requesters; round-robin grant, tagged response.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_b,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [DATA_WIDTH:0]                  rsp_sum,
    output logic [$clog2(NUM_REQ)-1:0]           rsp_id,
    output logic                                 busy,
    output logic [CNT_WIDTH-1:0]                 txn_count
);

    localparam int IDW = req_id_width(NUM_REQ);
    typedef logic unsigned [DATA_WIDTH:0] sum_w_t;

    state_e                state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, id_q, rsp_id_q, grant_id;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    sum_w_t                sum_q;
    logic [CNT_WIDTH-1:0]  txn_q;
    logic [NUM_REQ-1:0]    grant;
    logic                  any_req;
    logic                  rsp_hs;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .en       (state_q == IDLE),
        .grant    (grant),
        .grant_id (grant_id),
        .any_req  (any_req)
    );

    // A grant is only issued to a valid requester, so any_req is the request handshake.
    assign rsp_hs = (state_q == RESP) && rsp_ready;

    always_comb begin
        state_d   = state_q;
        req_ready = grant;
        rsp_valid = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: if (any_req) state_d = CALC;
            CALC: state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            sum_q    <= '0;
            rsp_id_q <= '0;
            txn_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                a_q  <= req_a[grant_id];
                b_q  <= req_b[grant_id];
                id_q <= grant_id;
            end
            if (state_q == CALC) begin
                sum_q    <= sum_w_t'(a_q) + sum_w_t'(b_q);
                rsp_id_q <= id_q;
            end
            if (rsp_hs) begin
                rr_ptr_q <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                txn_q    <= txn_q + 1'b1;
            end
        end
    end

    assign rsp_sum   = sum_q;
    assign rsp_id    = rsp_id_q;
    assign txn_count = txn_q;

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_rsp_stable:   assert property (@(posedge clk) disable iff (rst)
                        rsp_valid && !rsp_ready |=> $stable(rsp_sum) && $stable(rsp_id));
    a_rsp_in_resp:  assert property (@(posedge clk) disable iff (rst) rsp_valid |-> state_q == RESP);
`endif

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with a transaction-level reference model.
module tb_adder_share_ctrl;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CW  = 8;   // narrow counter so the wrap is reachable quickly
    localparam int IDW = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           req_valid, req_ready;
    logic [N-1:0][DW-1:0]   req_a, req_b;
    logic                   rsp_valid, rsp_ready;
    logic [DW:0]            rsp_sum;
    logic [IDW-1:0]         rsp_id;
    logic                   busy;
    logic [CW-1:0]          txn_count;

    adder_share_ctrl #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id),
        .busy(busy), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one transaction in flight, response visible two cycles after grant.
    bit          m_busy;
    int          m_age, m_ptr, m_id, cyc, g;
    logic [DW:0] m_sum;
    logic [CW-1:0] m_cnt;
    logic [N-1:0]  exp_ready;
    int          rsp_ids[$];
    int          rsp_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 0; m_age = 0; m_ptr = 0; m_id = 0; m_cnt = '0;
            chk("m_rst_ready", req_ready, 0);
            chk("m_rst_rvalid", rsp_valid, 0);
            chk("m_rst_busy", busy, 0);
            chk("m_rst_sum", rsp_sum, 0);
            chk("m_rst_id", rsp_id, 0);
            chk("m_rst_cnt", txn_count, 0);
        end else begin
            g = -1;
            if (!m_busy)
                for (int i = 0; i < N; i++)
                    if (g < 0 && req_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("m_ready", req_ready, exp_ready);
            chk("m_busy", busy, m_busy);
            chk("m_rvalid", rsp_valid, m_busy && m_age >= 2);
            chk("m_cnt", txn_count, m_cnt);
            if (m_busy && m_age >= 2) begin
                chk("m_sum", rsp_sum, m_sum);
                chk("m_id", rsp_id, m_id);
            end
            if (!m_busy) begin
                if (g >= 0) begin
                    m_busy = 1; m_age = 1; m_id = g;
                    m_sum = {1'b0, req_a[g]} + {1'b0, req_b[g]};
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (rsp_ready) begin
                m_busy = 0;
                m_ptr  = (m_id + 1) % N;
                m_cnt  = m_cnt + 1'b1;
                rsp_ids.push_back(m_id);
                rsp_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int max_cyc);
        bit seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1;
        end
        if (!seen) chk("wait_rsp_timeout", rsp_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [CW-1:0] c0;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_cnt", txn_count, 0);
        tick(); rst = 1'b0;

        // single request: 200 + 100 on requester 1
        req_a[1] = 8'd200; req_b[1] = 8'd100; req_valid = 4'b0010; rsp_ready = 1'b1;
        @(negedge clk); chk("t1_ready", req_ready, 4'b0010);
        tick(); req_valid = '0;
        @(negedge clk); chk("t1_calc_rvalid", rsp_valid, 0);
        tick();
        @(negedge clk);
        chk("t1_rvalid", rsp_valid, 1);
        chk("t1_sum", rsp_sum, 9'd300);
        chk("t1_id", rsp_id, 1);
        tick();
        @(negedge clk); chk("t1_cnt", txn_count, 1);

        // all four valid after a fresh reset
        tick(); rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[i] = 8'(16 * i + 3);
            req_b[i] = 8'(i + 1);
        end
        rsp_ids.delete(); rsp_cyc.delete();
        req_valid = 4'hF;
        repeat (15) tick();
        req_valid = '0;
        @(negedge clk);
        chk("rr_count", rsp_ids.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < rsp_ids.size()) chk($sformatf("rr_order%0d", i), rsp_ids[i], exp_order[i]);
        for (int i = 1; i < rsp_cyc.size(); i++)
            chk($sformatf("rr_gap%0d", i), rsp_cyc[i] - rsp_cyc[i-1], 3);

        // backpressure with max operands on requester 2
        tick();
        req_a[2] = 8'hFF; req_b[2] = 8'hFF; req_valid = 4'b0100; rsp_ready = 1'b0;
        wait_rsp(10);
        c0 = txn_count;
        chk("bp_sum", rsp_sum, 9'h1FE);
        chk("bp_id", rsp_id, 2);
        for (int k = 0; k < 5; k++) begin
            tick(); req_valid = 4'hF;
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_sum", rsp_sum, 9'h1FE);
            chk("bp_hold_id", rsp_id, 2);
            chk("bp_ready_low", req_ready, 0);
        end
        tick(); req_valid = '0; rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_one_done", txn_count, c0 + 1'b1);
        chk("bp_rvalid_low", rsp_valid, 0);

        // carry out: 0xFF + 0x01 on requester 3
        tick();
        req_a[3] = 8'hFF; req_b[3] = 8'h01; req_valid = 4'b1000;
        wait_rsp(10);
        chk("carry_sum", rsp_sum, 9'h100);
        chk("carry_id", rsp_id, 3);
        tick();

        // reset while requester 2 is in CALC
        req_a[2] = 8'd7; req_b[2] = 8'd9; req_valid = 4'b0100;
        tick(); req_valid = '0; rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_rvalid", rsp_valid, 0);
        chk("midrst_sum", rsp_sum, 0);
        chk("midrst_cnt", txn_count, 0);
        tick(); tick(); rst = 1'b0; req_valid = 4'hF;
        @(negedge clk); chk("postrst_grant", req_ready, 4'b0001);
        tick(); req_valid = '0;
        wait_rsp(5);
        chk("postrst_id", rsp_id, 0);
        tick();

        // withdrawal: requester 3 drops before the controller returns to IDLE at rr_ptr=3
        req_valid = 4'b0100; rsp_ready = 1'b0;
        wait_rsp(10);
        tick(); req_valid = 4'b1001;
        tick();
        tick(); req_valid = 4'b0001;
        tick(); rsp_ready = 1'b1;
        tick();
        @(negedge clk); chk("withdraw_grant", req_ready, 4'b0001);

        // counter wrap
        for (int i = 0; i < 1000; i++) begin
            tick();
            @(negedge clk);
            if (txn_count === 8'hFF) break;
        end
        chk("cnt_ff", txn_count, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            if (txn_count !== 8'hFF) break;
        end
        chk("cnt_wrap", txn_count, 8'h00);
        tick(); req_valid = '0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
